// File: rtl/reaction_timer_core_if.sv
// Player-facing signal bundle of the reaction timer core.
// The core attaches as slave; the driving game layer as master.
interface reaction_timer_core_if #(
    parameter int SCORE_W = 14,
    parameter int RNG_W   = 8,
    parameter int TRIALS  = 4
) ();
    localparam int IDX_W = $clog2(TRIALS + 1);

    logic [RNG_W-1:0]   iPRNG;
    logic               iStart;
    logic               iResponse;
    logic               oStimulus;
    logic               oTrialDone;
    logic               oFalseStart;
    logic               oSessionDone;
    logic [IDX_W-1:0]   oTrialIdx;
    logic [3:0]         oFalseCount;
    logic [SCORE_W-1:0] oCurrentScore;
    logic [SCORE_W-1:0] oAvgScore;
    logic [SCORE_W-1:0] oBestScore;

    modport master (
        output iPRNG, iStart, iResponse,
        input  oStimulus, oTrialDone, oFalseStart, oSessionDone,
        input  oTrialIdx, oFalseCount,
        input  oCurrentScore, oAvgScore, oBestScore
    );

    modport slave (
        input  iPRNG, iStart, iResponse,
        output oStimulus, oTrialDone, oFalseStart, oSessionDone,
        output oTrialIdx, oFalseCount,
        output oCurrentScore, oAvgScore, oBestScore
    );
endinterface

// File: rtl/reaction_timer_core.sv
// Reaction-time engine: random delay, tick-based scoring, session stats.
// Single clock domain; a prescaler tick enable replaces derived clocks.
module reaction_timer_core #(
    parameter int CLK_DIV    = 50000,
    parameter int SCORE_W    = 14,
    parameter int RNG_W      = 8,
    parameter int DELAY_MIN  = 300,
    parameter int DELAY_SPAN = 3000,
    parameter int TRIALS     = 4
) (
    input  logic                 clk,
    input  logic                 iReset,
    reaction_timer_core_if.slave bus
);
    localparam int PS_W   = $clog2(CLK_DIV);
    localparam int LOG_T  = $clog2(TRIALS);
    localparam int IDX_W  = $clog2(TRIALS + 1);
    localparam int SUM_W  = SCORE_W + LOG_T;
    localparam int PROD_W = RNG_W + $clog2(DELAY_SPAN + 1);
    localparam int DLY_W  = $clog2(DELAY_MIN + DELAY_SPAN + 1);

    localparam logic [PS_W-1:0]    PS_LOAD   = PS_W'(CLK_DIV - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(TRIALS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DELAY,
        S_MEASURE,
        S_RESULT,
        S_DONE
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [PS_W-1:0]    r_presc, w_presc;
    logic [DLY_W-1:0]   r_delay, w_delay;
    logic [SCORE_W-1:0] r_score, w_score;
    logic [SUM_W-1:0]   r_sum, w_sum;
    logic [IDX_W-1:0]   r_idx, w_idx;
    logic [3:0]         r_fcnt, w_fcnt;
    logic [SCORE_W-1:0] r_cur, w_cur;
    logic [SCORE_W-1:0] r_avg, w_avg;
    logic [SCORE_W-1:0] r_best, w_best;
    logic               r_stim, w_stim;
    logic               r_tdone, w_tdone;
    logic               r_fs, w_fs;
    logic               r_done, w_done;

    logic               w_tick;
    logic               w_reload;
    logic               w_last;
    logic [PROD_W-1:0]  w_prod;
    logic [DLY_W-1:0]   w_delay_ld;
    logic [IDX_W-1:0]   w_idx_inc;
    logic [SUM_W-1:0]   w_sum_inc;

    assign w_tick     = (r_presc == '0);
    assign w_prod     = PROD_W'(bus.iPRNG) * PROD_W'(DELAY_SPAN);
    assign w_delay_ld = DLY_W'(DELAY_MIN) + DLY_W'(w_prod >> RNG_W);
    assign w_idx_inc  = r_idx + IDX_W'(1);
    assign w_last     = (w_idx_inc == IDX_LAST);
    assign w_sum_inc  = r_sum + SUM_W'(r_score);

    always_ff @(posedge clk) begin
        if (iReset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE, S_DONE:
                if (bus.iStart) w_next = S_DELAY;
            S_DELAY:
                if (!bus.iResponse && w_tick && r_delay == DLY_W'(1))
                    w_next = S_MEASURE;
            S_MEASURE:
                if (bus.iResponse || (w_tick && r_score == SCORE_MAX))
                    w_next = S_RESULT;
            S_RESULT:
                w_next = w_last ? S_DONE : S_DELAY;
            default:
                w_next = S_IDLE;
        endcase
    end

    // A press freezes the score, so RESULT reads r_score directly.
    always_comb begin
        w_reload = 1'b0;
        w_delay  = r_delay;
        w_score  = r_score;
        w_sum    = r_sum;
        w_idx    = r_idx;
        w_fcnt   = r_fcnt;
        w_cur    = r_cur;
        w_avg    = r_avg;
        w_best   = r_best;
        w_tdone  = 1'b0;
        w_fs     = 1'b0;
        unique case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.iStart) begin
                    w_sum    = '0;
                    w_idx    = '0;
                    w_fcnt   = '0;
                    w_delay  = w_delay_ld;
                    w_reload = 1'b1;
                end
            end
            S_DELAY: begin
                if (bus.iResponse) begin
                    w_fs = 1'b1;
                    if (r_fcnt != 4'hF) w_fcnt = r_fcnt + 4'd1;
                    w_delay  = w_delay_ld;
                    w_reload = 1'b1;
                end else if (w_tick) begin
                    w_delay = r_delay - DLY_W'(1);
                    if (w_next == S_MEASURE) begin
                        w_score  = '0;
                        w_reload = 1'b1;
                    end
                end
            end
            S_MEASURE: begin
                if (!bus.iResponse && w_tick && r_score != SCORE_MAX)
                    w_score = r_score + SCORE_W'(1);
            end
            S_RESULT: begin
                w_cur   = r_score;
                w_sum   = w_sum_inc;
                w_idx   = w_idx_inc;
                w_tdone = 1'b1;
                if (r_score < r_best) w_best = r_score;
                if (w_last) begin
                    w_avg = SCORE_W'(w_sum_inc >> LOG_T);
                end else begin
                    w_delay  = w_delay_ld;
                    w_reload = 1'b1;
                end
            end
            default: ;
        endcase
        w_stim  = (w_next == S_MEASURE);
        w_done  = (w_next == S_DONE);
        w_presc = (w_reload || w_tick) ? PS_LOAD : r_presc - PS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (iReset) begin
            r_presc <= '0;
            r_delay <= '0;
            r_score <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_fcnt  <= '0;
            r_cur   <= '0;
            r_avg   <= '0;
            r_best  <= '1;
            r_stim  <= 1'b0;
            r_tdone <= 1'b0;
            r_fs    <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_presc <= w_presc;
            r_delay <= w_delay;
            r_score <= w_score;
            r_sum   <= w_sum;
            r_idx   <= w_idx;
            r_fcnt  <= w_fcnt;
            r_cur   <= w_cur;
            r_avg   <= w_avg;
            r_best  <= w_best;
            r_stim  <= w_stim;
            r_tdone <= w_tdone;
            r_fs    <= w_fs;
            r_done  <= w_done;
        end
    end

    assign bus.oStimulus     = r_stim;
    assign bus.oTrialDone    = r_tdone;
    assign bus.oFalseStart   = r_fs;
    assign bus.oSessionDone  = r_done;
    assign bus.oTrialIdx     = r_idx;
    assign bus.oFalseCount   = r_fcnt;
    assign bus.oCurrentScore = r_cur;
    assign bus.oAvgScore     = r_avg;
    assign bus.oBestScore    = r_best;
endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core: directed scenarios plus random traffic,
// checked every cycle against a deadline-based behavioural model.
module tb_reaction_timer_core;
    localparam int C     = 4;
    localparam int SW    = 6;
    localparam int DMIN  = 2;
    localparam int DSPAN = 4;
    localparam int TR    = 2;
    localparam int MAXS  = 63;

    localparam int P_IDLE  = 0;
    localparam int P_DELAY = 1;
    localparam int P_MEAS  = 2;
    localparam int P_RES   = 3;
    localparam int P_DONE  = 4;

    logic clk = 1'b0;
    logic iReset;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    reaction_timer_core_if #(.SCORE_W(SW), .RNG_W(8), .TRIALS(TR)) bus ();

    reaction_timer_core #(
        .CLK_DIV(C), .SCORE_W(SW), .RNG_W(8),
        .DELAY_MIN(DMIN), .DELAY_SPAN(DSPAN), .TRIALS(TR)
    ) dut (
        .clk(clk),
        .iReset(iReset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic int dly(input int p);
        return DMIN + (p * DSPAN) / 256;
    endfunction

    // Model: phases with absolute edge deadlines, no prescaler.
    int ecount = 0;
    int phase  = P_IDLE;
    int due    = 0;
    int m0     = 0;
    int mscore = 0;
    int sess[$];
    int e_stim = 0, e_tdone = 0, e_fs = 0, e_done = 0;
    int e_idx = 0, e_fcnt = 0, e_cur = 0, e_avg = 0, e_best = MAXS;

    initial begin : model
        int s;
        forever begin
            @(posedge clk);
            ecount++;
            e_tdone = 0;
            e_fs    = 0;
            if (iReset) begin
                phase  = P_IDLE;
                e_idx  = 0;
                e_fcnt = 0;
                e_cur  = 0;
                e_avg  = 0;
                e_best = MAXS;
                sess.delete();
            end else begin
                case (phase)
                    P_IDLE, P_DONE: if (bus.iStart) begin
                        sess.delete();
                        e_idx  = 0;
                        e_fcnt = 0;
                        due    = ecount + dly(int'(bus.iPRNG)) * C;
                        phase  = P_DELAY;
                    end
                    P_DELAY: if (bus.iResponse) begin
                        e_fs = 1;
                        if (e_fcnt < 15) e_fcnt++;
                        due = ecount + dly(int'(bus.iPRNG)) * C;
                    end else if (ecount == due) begin
                        phase = P_MEAS;
                        m0    = ecount;
                    end
                    P_MEAS: if (bus.iResponse || ecount - m0 == (MAXS + 1) * C) begin
                        mscore = (ecount - m0 - 1) / C;
                        phase  = P_RES;
                    end
                    P_RES: begin
                        e_cur = mscore;
                        sess.push_back(mscore);
                        if (mscore < e_best) e_best = mscore;
                        e_idx++;
                        e_tdone = 1;
                        if (e_idx == TR) begin
                            s = 0;
                            foreach (sess[i]) s += sess[i];
                            e_avg = s / TR;
                            phase = P_DONE;
                        end else begin
                            due   = ecount + dly(int'(bus.iPRNG)) * C;
                            phase = P_DELAY;
                        end
                    end
                    default: phase = P_IDLE;
                endcase
            end
            e_stim = (phase == P_MEAS) ? 1 : 0;
            e_done = (phase == P_DONE) ? 1 : 0;
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("stim",  int'(bus.oStimulus),     e_stim);
                chk("tdone", int'(bus.oTrialDone),    e_tdone);
                chk("fs",    int'(bus.oFalseStart),   e_fs);
                chk("done",  int'(bus.oSessionDone),  e_done);
                chk("idx",   int'(bus.oTrialIdx),     e_idx);
                chk("fcnt",  int'(bus.oFalseCount),   e_fcnt);
                chk("cur",   int'(bus.oCurrentScore), e_cur);
                chk("avg",   int'(bus.oAvgScore),     e_avg);
                chk("best",  int'(bus.oBestScore),    e_best);
            end
        end
    end

    task automatic pulse_start(input logic [7:0] p);
        @(negedge clk);
        bus.iPRNG  = p;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
    endtask

    task automatic wait_rise(output int n);
        n = 0;
        while (!bus.oStimulus && n < 1000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rise_seen", int'(bus.oStimulus), 1);
    endtask

    task automatic respond(input int k);
        repeat (k - 1) @(posedge clk);
        @(negedge clk);
        bus.iResponse = 1'b1;
        @(negedge clk);
        bus.iResponse = 1'b0;
    endtask

    task automatic commit(input int score);
        @(posedge clk);
        #1;
        chk("commit_pulse", int'(bus.oTrialDone), 1);
        chk("commit_score", int'(bus.oCurrentScore), score);
        @(posedge clk);
        #1;
        chk("commit_one_cycle", int'(bus.oTrialDone), 0);
    endtask

    task automatic rand_run(input int cycles, input int resp_div);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            bus.iPRNG     = 8'($urandom);
            bus.iStart    = ($urandom_range(0, 19) == 0);
            bus.iResponse = ($urandom_range(0, resp_div - 1) == 0);
            iReset        = ($urandom_range(0, 1499) == 0);
        end
    endtask

    initial begin : main
        int n;
        iReset        = 1'b1;
        bus.iStart    = 1'b0;
        bus.iResponse = 1'b0;
        bus.iPRNG     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        iReset = 1'b0;
        cmp_en = 1'b1;
        chk("rst_best", int'(bus.oBestScore), 63);
        chk("rst_stim", int'(bus.oStimulus), 0);
        chk("rst_idx",  int'(bus.oTrialIdx), 0);

        pulse_start(8'h80);
        wait_rise(n);
        chk("delay_0x80", n, 16);
        bus.iPRNG = 8'h00;
        respond(10);
        commit(2);
        wait_rise(n);
        chk("next_trial_rise", n, 7);
        respond(8);
        commit(1);
        chk("s1_done", int'(bus.oSessionDone), 1);
        chk("s1_avg",  int'(bus.oAvgScore), 1);
        chk("s1_best", int'(bus.oBestScore), 1);
        chk("s1_idx",  int'(bus.oTrialIdx), 2);
        chk("s1_model_avg", e_avg, 1);

        pulse_start(8'($urandom));
        wait_rise(n);
        @(negedge clk);
        iReset = 1'b1;
        @(negedge clk);
        iReset = 1'b0;
        chk("mid_rst_stim", int'(bus.oStimulus), 0);
        chk("mid_rst_best", int'(bus.oBestScore), 63);
        chk("mid_rst_idx",  int'(bus.oTrialIdx), 0);

        pulse_start(8'h00);
        @(negedge clk);
        bus.iPRNG  = 8'h80;
        bus.iStart = 1'b1;
        @(negedge clk);
        bus.iStart = 1'b0;
        wait_rise(n);
        chk("start_ignored", n, 6);
        respond(14);
        commit(3);
        @(negedge clk);
        bus.iResponse = 1'b1;
        @(negedge clk);
        bus.iResponse = 1'b0;
        chk("fs_pulse", int'(bus.oFalseStart), 1);
        chk("fs_count", int'(bus.oFalseCount), 1);
        chk("fs_idx",   int'(bus.oTrialIdx), 1);
        wait_rise(n);
        chk("fs_restart", n, 16);
        chk("fs_cleared", int'(bus.oFalseStart), 0);
        respond(25);
        commit(6);
        chk("s2_done", int'(bus.oSessionDone), 1);
        chk("s2_avg",  int'(bus.oAvgScore), 4);
        chk("s2_best", int'(bus.oBestScore), 3);
        chk("s2_fcnt", int'(bus.oFalseCount), 1);
        chk("s2_model_avg", e_avg, 4);

        pulse_start(8'($urandom));
        wait_rise(n);
        respond(21);
        commit(5);
        wait_rise(n);
        respond(24);
        commit(5);
        chk("s3_avg",  int'(bus.oAvgScore), 5);
        chk("s3_best", int'(bus.oBestScore), 3);
        chk("s3_fcnt", int'(bus.oFalseCount), 0);

        pulse_start(8'($urandom));
        wait_rise(n);
        n = 0;
        while (!bus.oTrialDone && n < 400) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("timeout_seen",   int'(bus.oTrialDone), 1);
        chk("timeout_cycles", n, 257);
        chk("timeout_score",  int'(bus.oCurrentScore), 63);
        chk("timeout_best",   int'(bus.oBestScore), 3);
        wait_rise(n);
        respond(30);
        commit(7);
        chk("s4_avg", int'(bus.oAvgScore), 35);

        rand_run(3000, 25);
        rand_run(3000, 400);
        @(negedge clk);
        bus.iStart    = 1'b0;
        bus.iResponse = 1'b0;
        iReset        = 1'b0;
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
